// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and datapath width.
package mem_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PIPE = 2'b01,
    DBG  = 2'b10
  } arbState_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between pipeline and debug requesters.
// MEMARB_RR_EN selects round-robin on contention; otherwise pipeline priority with a starvation guard.
module mem_arb_pick #(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pReq,
  input  logic dReq,
  output logic pWin,
  output logic dWin
);

`ifdef MEMARB_RR_EN
  // Starts at "debug" so the pipeline takes the first conflict.
  logic lastDbg;

  always_comb begin
    dWin = dReq && (!pReq || !lastDbg);
    pWin = pReq && !dWin;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lastDbg <= 1'b1;
    end else if (pReq || dReq) begin
      lastDbg <= dWin;
    end
  end
`else
  logic [3:0] waitCnt;

  always_comb begin
    dWin = dReq && (!pReq || (waitCnt == 4'(MAX_WAIT)));
    pWin = pReq && !dWin;
  end

  // Counts consecutive lost cycles of a pending debug request.
  always_ff @(posedge clock) begin
    if (reset) begin
      waitCnt <= 4'd0;
    end else if (!dReq || dWin) begin
      waitCnt <= 4'd0;
    end else begin
      waitCnt <= waitCnt + 4'd1;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data memory arbiter between the pipeline MEM stage and a debug/loader port.
// Arbitration policy lives in mem_arb_pick (MEMARB_RR_EN selects round-robin).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_rm,
  input  logic              p_wm,
  input  logic [DATA_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              mem_Rm,
  output logic              mem_Wm,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arbState_t state, stateNext;
  logic      pReq, pWin, dWin;

  assign pReq = p_rm | p_wm;

  mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) uPick (
    .clock (clock),
    .reset (reset),
    .pReq  (pReq),
    .dReq  (d_req),
    .pWin  (pWin),
    .dWin  (dWin)
  );

  assign p_stall = !reset && pReq && dWin;
  assign d_gnt   = (state == DBG);

  always_comb begin
    stateNext = IDLE;
    if (dWin) begin
      stateNext = DBG;
    end else if (pWin) begin
      stateNext = PIPE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_Rm    <= 1'b0;
      mem_Wm    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      p_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= stateNext;

      // Return stage: capture read data for the access issued last cycle.
      p_rvalid <= (state == PIPE) && mem_Rm;
      d_rvalid <= (state == DBG) && mem_Rm;
      if ((state == PIPE) && mem_Rm) p_rdata <= mem_rdata;
      if ((state == DBG) && mem_Rm)  d_rdata <= mem_rdata;

      // Issue stage: latch the winner's access onto the memory port.
      case (stateNext)
        PIPE: begin
          mem_Wm    <= p_wm;
          mem_Rm    <= p_rm && !p_wm;
          mem_addr  <= p_addr;
          mem_wdata <= p_wdata;
        end
        DBG: begin
          mem_Wm    <= d_we;
          mem_Rm    <= !d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end
        default: begin
          mem_Wm <= 1'b0;
          mem_Rm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural 256x8 memory and read-data scoreboard.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       p_rm, p_wm, p_stall, p_rvalid;
  logic [7:0] p_addr, p_wdata, p_rdata;
  logic       d_req, d_we, d_gnt, d_rvalid;
  logic [7:0] d_addr, d_wdata, d_rdata;
  logic       mem_Rm, mem_Wm;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] memArr [256];
  logic [7:0] pq [$];
  logic [7:0] dq [$];
  int         total  = 0;
  int         passed = 0;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .p_rm      (p_rm),
    .p_wm      (p_wm),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_stall   (p_stall),
    .p_rdata   (p_rdata),
    .p_rvalid  (p_rvalid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rdata   (d_rdata),
    .d_rvalid  (d_rvalid),
    .mem_Rm    (mem_Rm),
    .mem_Wm    (mem_Wm),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = memArr[mem_addr];

  always @(posedge clock) begin
    if (mem_Wm) memArr[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one cycle and retire any read data against the scoreboard.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (p_rvalid) begin
      if (pq.size() == 0) chk("p_rvalid_unexpected", 1, 0);
      else chk("p_rdata", {24'd0, p_rdata}, {24'd0, pq.pop_front()});
    end
    if (d_rvalid) begin
      if (dq.size() == 0) chk("d_rvalid_unexpected", 1, 0);
      else chk("d_rdata", {24'd0, d_rdata}, {24'd0, dq.pop_front()});
    end
  endtask

  task automatic idleInputs();
    p_rm = 0; p_wm = 0; p_addr = 0; p_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
  endtask

  initial begin
    logic dExp;
    for (int i = 0; i < 256; i++) memArr[i] <= 8'(i) ^ 8'h5A;
    memArr[8'h10] <= 8'hA5;
    memArr[8'h40] <= 8'h77;

    // Reset with both requesters active: stall must stay low.
    reset = 1; idleInputs();
    p_rm = 1; p_addr = 8'h10; d_req = 1; d_addr = 8'h20;
    tick(); tick();
    chk("rst_p_stall", p_stall, 0);
    chk("rst_mem_strobes", {mem_Rm, mem_Wm}, 0);
    chk("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 0);
    chk("rst_gnt_valids", {d_gnt, p_rvalid, d_rvalid}, 0);
    chk("rst_rdata", {p_rdata, d_rdata}, 0);
    idleInputs();
    reset = 0;
    tick();

    // Pipeline read of 0x10.
    p_rm = 1; p_addr = 8'h10;
    chk("pr_stall", p_stall, 0);
    pq.push_back(8'hA5);
    tick();
    chk("pr_issue", {mem_Rm, mem_Wm, mem_addr}, {2'b10, 8'h10});
    chk("pr_rvalid_early", p_rvalid, 0);
    p_rm = 0;
    tick();
    chk("pr_rvalid", p_rvalid, 1);
    chk("pr_stall2", p_stall, 0);
    tick();
    chk("pr_rvalid_pulse", p_rvalid, 0);

    // Debug write 0x3C to 0x20.
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C;
    chk("dw_stall", p_stall, 0);
    tick();
    chk("dw_gnt", d_gnt, 1);
    chk("dw_issue", {mem_Rm, mem_Wm, mem_addr, mem_wdata}, {2'b01, 8'h20, 8'h3C});
    d_req = 0; d_we = 0;
    tick();
    chk("dw_gnt_pulse", {d_gnt, mem_Wm, d_rvalid}, 0);
    chk("dw_mem", memArr[8'h20], 8'h3C);

    // Debug read back of 0x20.
    d_req = 1; d_addr = 8'h20;
    dq.push_back(8'h3C);
    tick();
    chk("dr_gnt", d_gnt, 1);
    d_req = 0;
    tick();
    chk("dr_rvalid", d_rvalid, 1);
    tick();

    // Both requesters contend continuously for 8 cycles.
    p_rm = 1; p_addr = 8'h40;
    d_req = 1; d_addr = 8'h20;
    for (int i = 0; i < 8; i++) begin
`ifdef MEMARB_RR_EN
      dExp = (i % 2) == 1;
`else
      dExp = (i == 4);
`endif
      chk($sformatf("ct_stall_%0d", i), p_stall, dExp);
      if (dExp) dq.push_back(memArr[8'h20]);
      else pq.push_back(memArr[8'h40]);
      tick();
      chk($sformatf("ct_gnt_%0d", i), d_gnt, dExp);
      chk($sformatf("ct_addr_%0d", i), mem_addr, dExp ? 8'h20 : 8'h40);
    end
    idleInputs();
    tick(); tick();

    // Simultaneous read and write: the write wins, no read data.
    p_rm = 1; p_wm = 1; p_addr = 8'h30; p_wdata = 8'h5A;
    tick();
    chk("rw_issue", {mem_Rm, mem_Wm, mem_addr, mem_wdata}, {2'b01, 8'h30, 8'h5A});
    idleInputs();
    tick();
    chk("rw_no_rvalid", p_rvalid, 0);
    chk("rw_mem", memArr[8'h30], 8'h5A);
    tick();

    // Reset arrives while a read is in flight.
    p_rm = 1; p_addr = 8'h10;
    tick();
    chk("rr_issue", mem_Rm, 1);
    idleInputs();
    reset = 1;
    tick();
    chk("rr_outputs", {p_rvalid, d_rvalid, d_gnt, mem_Rm, mem_Wm, p_stall}, 0);
    chk("rr_data", {mem_addr, mem_wdata, p_rdata, d_rdata}, 0);
    reset = 0;
    tick();
    chk("rr_no_rvalid", p_rvalid, 0);
    tick();

    chk("sb_p_drained", pq.size(), 0);
    chk("sb_d_drained", dq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 4, number of consecutive lost cycles after which a pending debug request is forced to win (range 1..15).
REQ-002 clock  input  1  single clock, all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 p_rm / p_wm  input  1 each  pipeline MEM-stage read / write strobe.
REQ-005 p_addr / p_wdata  input  8 each  pipeline address / store data.
REQ-006 p_stall  output  1  pipeline must hold its MEM-stage request.
REQ-007 p_rdata / p_rvalid  output  8 / 1  pipeline read data / one-cycle valid pulse.
REQ-008 d_req / d_we  input  1 each  debug/loader port request / write-enable.
REQ-009 d_addr / d_wdata  input  8 each  debug address / write data.
REQ-010 d_gnt  output  1  one-cycle pulse: debug request accepted.
REQ-011 d_rdata / d_rvalid  output  8 / 1  debug read data / one-cycle valid pulse.
REQ-012 mem_Rm / mem_Wm  output  1 each  registered strobes to the single-port 256x8 data memory.
REQ-013 mem_addr / mem_wdata  output  8 each  registered address / write data to memory.
REQ-014 mem_rdata  input  8  combinational memory read data.

Function
REQ-015 FSM states: IDLE, PIPE, DBG; PIPE/DBG last exactly one cycle per access.
REQ-016 A pipeline request is p_rm|p_wm; if both are set, write takes precedence and no read data is returned.
REQ-017 At each posedge in any state, the arbiter samples both requests, latches the winner's address/data/strobe into mem_*, and enters PIPE or DBG; with no request it enters IDLE with mem_Rm=mem_Wm=0.
REQ-018 Back-to-back accesses are allowed: one access per cycle, no idle bubble.
REQ-019 Default priority: pipeline wins.
REQ-020 wait_cnt (4 bits) increments each cycle d_req=1 and debug loses; it clears when debug wins or d_req=0; when wait_cnt==MAX_WAIT, debug wins.
REQ-021 p_stall=1 combinationally whenever a pipeline request is present and debug wins the current arbitration; otherwise 0.
REQ-022 d_gnt pulses in the cycle the debug request is latched (DBG state cycle); d_req must be held until d_gnt.
REQ-023 Read latency: request sampled at edge N; strobe cycle N..N+1; mem_rdata captured at edge N+1 into p_rdata/d_rdata; rvalid high cycle N+1..N+2.
REQ-024 p_rdata/d_rdata hold their last value until the next read for that requester.
REQ-025 Writes produce no rvalid.
REQ-026 Addresses are 8-bit, full 0x00-0xFF, no wrap logic needed.

Reset
REQ-027 reset=1 at a posedge forces IDLE, wait_cnt=0, all mem_* outputs, d_gnt, p_rvalid, d_rvalid, p_rdata, d_rdata = 0.
REQ-028 An access in flight when reset asserts is abandoned: no rvalid and no d_gnt is issued.
REQ-029 p_stall evaluates to 0 while reset is high.

Configuration
REQ-030 MEMARB_RR_EN defined: when both requesters contend, the winner alternates, with the last-winner flag reset to "debug" so that pipeline wins the first conflict; wait_cnt logic is compiled out.
REQ-031 MEMARB_RR_EN undefined: fixed pipeline priority with the MAX_WAIT starvation guard (REQ-019, REQ-020).

Structure
REQ-032 The shared package holds the FSM state encoding (IDLE=2'b00, PIPE=2'b01, DBG=2'b10) and the 8-bit data/address width constant.
REQ-033 The grant decision (priority plus starvation or round-robin) is a sub-module, mem_arb_pick; the FSM and datapath registers live in mem_arbiter.

Verification
REQ-034 Pipeline read only: p_rm=1, p_addr=0x10, memory[0x10]=0xA5 -> p_rvalid one cycle, 2 edges later, p_rdata=0xA5; p_stall=0 throughout.
REQ-035 Debug write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x3C, pipeline idle -> d_gnt pulse, mem_Wm=1 for one cycle with mem_addr=0x20, mem_wdata=0x3C.
REQ-036 Contention with MEMARB_RR_EN undefined and MAX_WAIT=4: both request continuously -> pipeline wins 4 cycles, then debug wins the 5th cycle with p_stall=1 in that cycle only.
REQ-037 Contention with MEMARB_RR_EN defined: both request continuously -> grants alternate P,D,P,D, with pipeline winning first.
REQ-038 Reset mid-read: pipeline read latched, then reset=1 at the next edge -> p_rvalid never asserts and all outputs are 0.
REQ-039 Simultaneous p_rm=p_wm=1 at 0x30 -> a write occurs and p_rvalid stays 0.
